// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 set-2 to ASCII keyboard front end.
// Holds ps2_key field positions, modifier/special scancodes, ASCII control
// codes and the caps/ctrl modifier function applied after the ROM lookup.
package ps2_kbd_pkg;

  localparam int unsigned KEY_W      = 11;
  localparam int unsigned KEY_TOGGLE = 10;
  localparam int unsigned KEY_PRESS  = 9;
  localparam int unsigned KEY_EXT    = 8;
  localparam int unsigned CODE_W     = 8;
  localparam int unsigned CHAR_W     = 8;
  localparam int unsigned ROM_AW     = CODE_W + 1;

  localparam logic [CODE_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [CODE_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [CODE_W-1:0] SC_CTRL   = 8'h14;
  localparam logic [CODE_W-1:0] SC_CAPS   = 8'h58;
  localparam logic [CODE_W-1:0] SC_ENTER  = 8'h5A;
  localparam logic [CODE_W-1:0] SC_SLASH  = 8'h4A;
  localparam logic [CODE_W-1:0] SC_BKSP   = 8'h66;
  localparam logic [CODE_W-1:0] SC_ESC    = 8'h76;
  localparam logic [CODE_W-1:0] SC_TAB    = 8'h0D;
  localparam logic [CODE_W-1:0] SC_SPACE  = 8'h29;

  localparam logic [CHAR_W-1:0] ASCII_CR    = 8'h0D;
  localparam logic [CHAR_W-1:0] ASCII_DEL   = 8'h7F;
  localparam logic [CHAR_W-1:0] ASCII_ESC   = 8'h1B;
  localparam logic [CHAR_W-1:0] ASCII_TAB   = 8'h09;
  localparam logic [CHAR_W-1:0] ASCII_SPACE = 8'h20;

  // Caps swaps letter case first, then ctrl folds 0x40-0x7F onto 0x00-0x1F.
  function automatic logic [CHAR_W-1:0] apply_mods(input logic [CHAR_W-1:0] c,
                                                   input logic caps,
                                                   input logic ctrl);
    logic [CHAR_W-1:0] r;
    r = c;
    if (caps && (((r >= 8'h41) && (r <= 8'h5A)) || ((r >= 8'h61) && (r <= 8'h7A))))
      r = r ^ 8'h20;
    if (ctrl && (r >= 8'h40) && (r <= 8'h7F))
      r = r & 8'h1F;
    return r;
  endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Synchronous 512x8 US-layout translation ROM, one-cycle latency.
// Ports: clk_sys/reset_n clock and async reset; addr = {shift, scancode};
// data = registered ASCII character, 0x00 when the key has no character.
module ps2_ascii_rom
  import ps2_kbd_pkg::*;
(
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [ROM_AW-1:0] addr,
  output logic [CHAR_W-1:0] data
);

  logic              sh;
  logic [CODE_W-1:0] code;
  logic [CHAR_W-1:0] lut_c;

  assign sh   = addr[ROM_AW-1];
  assign code = addr[CODE_W-1:0];

  // Lower half of the ROM is unshifted, upper half shifted.
  always_comb begin
    lut_c = 8'h00;
    case (code)
      SC_TAB:   lut_c = ASCII_TAB;
      SC_SPACE: lut_c = ASCII_SPACE;
      SC_ENTER: lut_c = ASCII_CR;
      SC_BKSP:  lut_c = ASCII_DEL;
      SC_ESC:   lut_c = ASCII_ESC;
      8'h0E: lut_c = sh ? 8'h7E : 8'h60;
      8'h15: lut_c = sh ? "Q" : "q";
      8'h16: lut_c = sh ? "!" : "1";
      8'h1A: lut_c = sh ? "Z" : "z";
      8'h1B: lut_c = sh ? "S" : "s";
      8'h1C: lut_c = sh ? "A" : "a";
      8'h1D: lut_c = sh ? "W" : "w";
      8'h1E: lut_c = sh ? "@" : "2";
      8'h21: lut_c = sh ? "C" : "c";
      8'h22: lut_c = sh ? "X" : "x";
      8'h23: lut_c = sh ? "D" : "d";
      8'h24: lut_c = sh ? "E" : "e";
      8'h25: lut_c = sh ? "$" : "4";
      8'h26: lut_c = sh ? "#" : "3";
      8'h2A: lut_c = sh ? "V" : "v";
      8'h2B: lut_c = sh ? "F" : "f";
      8'h2C: lut_c = sh ? "T" : "t";
      8'h2D: lut_c = sh ? "R" : "r";
      8'h2E: lut_c = sh ? "%" : "5";
      8'h31: lut_c = sh ? "N" : "n";
      8'h32: lut_c = sh ? "B" : "b";
      8'h33: lut_c = sh ? "H" : "h";
      8'h34: lut_c = sh ? "G" : "g";
      8'h35: lut_c = sh ? "Y" : "y";
      8'h36: lut_c = sh ? "^" : "6";
      8'h3A: lut_c = sh ? "M" : "m";
      8'h3B: lut_c = sh ? "J" : "j";
      8'h3C: lut_c = sh ? "U" : "u";
      8'h3D: lut_c = sh ? "&" : "7";
      8'h3E: lut_c = sh ? "*" : "8";
      8'h41: lut_c = sh ? "<" : ",";
      8'h42: lut_c = sh ? "K" : "k";
      8'h43: lut_c = sh ? "I" : "i";
      8'h44: lut_c = sh ? "O" : "o";
      8'h45: lut_c = sh ? ")" : "0";
      8'h46: lut_c = sh ? "(" : "9";
      8'h49: lut_c = sh ? ">" : ".";
      8'h4A: lut_c = sh ? "?" : "/";
      8'h4B: lut_c = sh ? "L" : "l";
      8'h4C: lut_c = sh ? ":" : ";";
      8'h4D: lut_c = sh ? "P" : "p";
      8'h4E: lut_c = sh ? "_" : "-";
      8'h52: lut_c = sh ? "\"" : "'";
      8'h54: lut_c = sh ? "{" : "[";
      8'h55: lut_c = sh ? "+" : "=";
      8'h5B: lut_c = sh ? "}" : "]";
      8'h5D: lut_c = sh ? "|" : "\\";
      default: lut_c = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) data <= '0;
    else          data <= lut_c;
  end

endmodule

// File: rtl/ps2_ascii_kbd.sv
// PS/2 key-event to ASCII converter with modifier tracking and output FIFO.
// Ports: clk_sys, reset_n (async, active-low); ps2_key = {toggle, press,
// ext, scancode}; ascii_data/ascii_valid/ascii_ready = FIFO head handshake;
// fifo_count occupancy; overflow sticky drop flag cleared by ovf_clr;
// caps_led current caps-lock state.
module ps2_ascii_kbd
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic        CAPS_INIT  = 1'b0
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic [KEY_W-1:0]            ps2_key,
  output logic [CHAR_W-1:0]           ascii_data,
  output logic                        ascii_valid,
  input  logic                        ascii_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        ovf_clr,
  output logic                        caps_led
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Stage 1: event detect, modifier state, capture of lookup context.
  logic              tog_q, primed_q;
  logic              lshift_q, rshift_q, ctrl_q, caps_q;
  logic              s1_valid, s1_shift, s1_caps, s1_ctrl;
  logic [CODE_W-1:0] s1_code;
  logic [CODE_W-1:0] code_c;
  logic              ext_c, press_c, event_c;
  logic              is_lshift_c, is_rshift_c, is_ctrl_c, is_caps_c, char_ev_c;

  assign code_c      = ps2_key[CODE_W-1:0];
  assign ext_c       = ps2_key[KEY_EXT];
  assign press_c     = ps2_key[KEY_PRESS];
  assign event_c     = primed_q & (ps2_key[KEY_TOGGLE] != tog_q);
  assign is_lshift_c = ~ext_c & (code_c == SC_LSHIFT);
  assign is_rshift_c = ~ext_c & (code_c == SC_RSHIFT);
  assign is_ctrl_c   = (code_c == SC_CTRL);
  assign is_caps_c   = ~ext_c & (code_c == SC_CAPS);
  // Only non-modifier presses reach the ROM; extended keys only Enter and '/'.
  assign char_ev_c   = event_c & press_c
                     & ~(is_lshift_c | is_rshift_c | is_ctrl_c | is_caps_c)
                     & (~ext_c | (code_c == SC_ENTER) | (code_c == SC_SLASH));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q    <= 1'b0;
      primed_q <= 1'b0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      ctrl_q   <= 1'b0;
      caps_q   <= CAPS_INIT;
      s1_valid <= 1'b0;
      s1_shift <= 1'b0;
      s1_caps  <= 1'b0;
      s1_ctrl  <= 1'b0;
      s1_code  <= '0;
    end else begin
      tog_q    <= ps2_key[KEY_TOGGLE];
      primed_q <= 1'b1;
      s1_valid <= char_ev_c;
      s1_code  <= code_c;
      // Extended keys look up unshifted so E0-4A always yields '/'.
      s1_shift <= (lshift_q | rshift_q) & ~ext_c;
      s1_caps  <= caps_q;
      s1_ctrl  <= ctrl_q;
      if (event_c) begin
        if (is_lshift_c)          lshift_q <= press_c;
        if (is_rshift_c)          rshift_q <= press_c;
        if (is_ctrl_c)            ctrl_q   <= press_c;
        if (is_caps_c && press_c) caps_q   <= ~caps_q;
      end
    end
  end

  // Stage 2: ROM lookup alongside the modifier context.
  logic [CHAR_W-1:0] rom_data;
  logic              s2_valid, s2_caps, s2_ctrl;

  ps2_ascii_rom u_rom (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .addr    ({s1_shift, s1_code}),
    .data    (rom_data)
  );

  // Stage 3: apply caps/ctrl, keep only keys that have a ROM character.
  logic              s3_valid;
  logic [CHAR_W-1:0] s3_char;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_caps  <= 1'b0;
      s2_ctrl  <= 1'b0;
      s3_valid <= 1'b0;
      s3_char  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_caps  <= s1_caps;
      s2_ctrl  <= s1_ctrl;
      s3_valid <= s2_valid & (rom_data != 8'h00);
      s3_char  <= apply_mods(rom_data, s2_caps, s2_ctrl);
    end
  end

  // Output buffer with registered head, valid and count.
  logic [CHAR_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     rd_q, wr_q, rd_n_c;
  logic [CW-1:0]     cnt_q, cnt_n_c;
  logic [CHAR_W-1:0] head_q, head_n_c;
  logic              valid_q, ovf_q;
  logic              pop_c, full_c, wr_en_c, drop_c;

  always_comb begin
    pop_c    = valid_q & ascii_ready;
    full_c   = (cnt_q == CW'(FIFO_DEPTH));
    wr_en_c  = s3_valid & (~full_c | pop_c);
    drop_c   = s3_valid & full_c & ~pop_c;
    rd_n_c   = pop_c ? rd_q + PW'(1) : rd_q;
    cnt_n_c  = cnt_q;
    if (wr_en_c && !pop_c)      cnt_n_c = cnt_q + CW'(1);
    else if (pop_c && !wr_en_c) cnt_n_c = cnt_q - CW'(1);
    // The new head is the incoming char when it lands in the head slot.
    head_n_c = 8'h00;
    if (cnt_n_c != CW'(0))
      head_n_c = (wr_en_c && (wr_q == rd_n_c)) ? s3_char : mem_q[rd_n_c];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en_c) begin
        mem_q[wr_q] <= s3_char;
        wr_q        <= wr_q + PW'(1);
      end
      rd_q    <= rd_n_c;
      cnt_q   <= cnt_n_c;
      head_q  <= head_n_c;
      valid_q <= (cnt_n_c != CW'(0));
      if (drop_c)       ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign ascii_data  = head_q;
  assign ascii_valid = valid_q;
  assign fifo_count  = cnt_q;
  assign overflow    = ovf_q;
  assign caps_led    = caps_q;

endmodule

// File: tb/tb_ps2_ascii_kbd.sv
// Self-checking bench for ps2_ascii_kbd: directed scenarios followed by
// random key traffic, all compared against a queue-based reference model.
module tb_ps2_ascii_kbd;

  localparam int unsigned DEPTH = 8;
  localparam logic        CINIT = 1'b0;
  localparam int          NTBL  = 38;

  logic                      clk_sys = 1'b0;
  logic                      reset_n = 1'b1;
  logic [10:0]               ps2_key = '0;
  logic [7:0]                ascii_data;
  logic                      ascii_valid;
  logic                      ascii_ready = 1'b0;
  logic [$clog2(DEPTH):0]    fifo_count;
  logic                      overflow;
  logic                      ovf_clr = 1'b0;
  logic                      caps_led;

  always #5 clk_sys = ~clk_sys;

  ps2_ascii_kbd #(.FIFO_DEPTH(DEPTH), .CAPS_INIT(CINIT)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_key     (ps2_key),
    .ascii_data  (ascii_data),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .caps_led    (caps_led)
  );

  // {scancode, unshifted char, shifted char}, US layout.
  logic [23:0] tbl [NTBL] = '{
    24'h1C6141, 24'h326242, 24'h216343, 24'h236444, 24'h246545, 24'h2B6646,
    24'h346747, 24'h336848, 24'h436949, 24'h3B6A4A, 24'h426B4B, 24'h4B6C4C,
    24'h3A6D4D, 24'h316E4E, 24'h446F4F, 24'h4D7050, 24'h157151, 24'h2D7252,
    24'h1B7353, 24'h2C7454, 24'h3C7555, 24'h2A7656, 24'h1D7757, 24'h227858,
    24'h357959, 24'h1A7A5A, 24'h163121, 24'h1E3240, 24'h453029, 24'h4A2F3F,
    24'h545B7B, 24'h5B5D7D, 24'h0E607E, 24'h5A0D0D, 24'h667F7F, 24'h761B1B,
    24'h0D0909, 24'h292020
  };
  logic [7:0] mods [4] = '{8'h12, 8'h59, 8'h14, 8'h58};
  logic [7:0] extc [5] = '{8'h5A, 8'h4A, 8'h75, 8'h14, 8'h6B};

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  int fq [$];
  int pend_c [$];
  int pend_due [$];
  bit m_shl, m_shr, m_ctrl, m_caps, m_ovf, m_tog, m_primed;
  int edge_no = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [7:0] code, input bit sh);
    for (int i = 0; i < NTBL; i++)
      if (tbl[i][23:16] == code) return sh ? int'(tbl[i][7:0]) : int'(tbl[i][15:8]);
    return 0;
  endfunction

  function automatic int ref_char(input bit ext, input logic [7:0] code);
    int c;
    if (ext) c = (code == 8'h5A) ? 13 : (code == 8'h4A) ? 47 : 0;
    else     c = lookup(code, m_shl || m_shr);
    if (c == 0) return -1;
    if (m_caps && ((c >= 65 && c <= 90) || (c >= 97 && c <= 122)))
      c = (c >= 97) ? c - 32 : c + 32;
    if (m_ctrl && c >= 64 && c <= 127) c = c % 32;
    return c;
  endfunction

  task automatic model_event(input bit pr, input bit ext, input logic [7:0] code);
    int c;
    if (!ext && code == 8'h12)      m_shl = pr;
    else if (!ext && code == 8'h59) m_shr = pr;
    else if (code == 8'h14)         m_ctrl = pr;
    else if (!ext && code == 8'h58) begin
      if (pr) m_caps = !m_caps;
    end else if (pr) begin
      c = ref_char(ext, code);
      if (c >= 0) begin
        pend_c.push_back(c);
        pend_due.push_back(edge_no + 3);
      end
    end
  endtask

  task automatic model_edge();
    bit pop, full, have, acc;
    int c;
    pop  = (fq.size() > 0) && ascii_ready;
    full = (fq.size() == DEPTH);
    have = (pend_due.size() > 0) && (pend_due[0] == edge_no);
    acc  = have && (!full || pop);
    if (have && !acc) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (pop) void'(fq.pop_front());
    if (have) begin
      c = pend_c.pop_front();
      void'(pend_due.pop_front());
      if (acc) fq.push_back(c);
    end
    if (m_primed && (ps2_key[10] != m_tog)) model_event(ps2_key[9], ps2_key[8], ps2_key[7:0]);
    m_tog    = ps2_key[10];
    m_primed = 1'b1;
  endtask

  task automatic compare_all();
    chk("count", 32'(fifo_count), 32'(fq.size()));
    chk("valid", 32'(ascii_valid), 32'(fq.size() != 0));
    if (fq.size() != 0) chk("data", 32'(ascii_data), 32'(fq[0]));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("caps", 32'(caps_led), 32'(m_caps));
  endtask

  // Inputs are set at the falling edge; model follows the rising edge.
  task automatic step(input bit rdy, input bit clr);
    ascii_ready = rdy;
    ovf_clr     = clr;
    @(posedge clk_sys);
    edge_no++;
    if (reset_n) model_edge();
    @(negedge clk_sys);
    compare_all();
  endtask

  task automatic ev(input bit pr, input bit ext, input logic [7:0] code, input bit rdy);
    ps2_key = {~ps2_key[10], pr, ext, code};
    step(rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (fq.size() > 0 || pend_c.size() > 0); i++) step(1'b1, 1'b0);
    chk("drain_empty", 32'(fifo_count), 32'h0);
  endtask

  task automatic do_reset(input bit tog, input int hold);
    ps2_key     = {tog, 10'h000};
    ascii_ready = 1'b0;
    ovf_clr     = 1'b0;
    reset_n     = 1'b0;
    #1;
    fq.delete();
    pend_c.delete();
    pend_due.delete();
    m_shl = 0; m_shr = 0; m_ctrl = 0; m_caps = CINIT; m_ovf = 0; m_primed = 0;
    compare_all();
    chk("rst_data", 32'(ascii_data), 32'h0);
    repeat (hold) @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] code;
    bit         pr, ext;
    int         r;

    // Reset release with toggle high: no spurious character.
    do_reset(1'b1, 2);
    idle(4, 1'b0);
    chk("r036_count", 32'(fifo_count), 32'h0);

    // Plain 'a' and its latency.
    ev(1'b1, 1'b0, 8'h1C, 1'b0);
    idle(2, 1'b0);
    chk("lat_not_yet", 32'(ascii_valid), 32'h0);
    idle(1, 1'b0);
    chk("lat_valid", 32'(ascii_valid), 32'h1);
    chk("a_lower", 32'(ascii_data), 32'h61);
    drain();

    // Shift then 'A'; caps with shift held back to 'a'.
    ev(1'b1, 1'b0, 8'h12, 1'b0);
    ev(1'b1, 1'b0, 8'h1C, 1'b0);
    idle(3, 1'b0);
    chk("a_shift", 32'(ascii_data), 32'h41);
    drain();
    ev(1'b1, 1'b0, 8'h58, 1'b0);
    ev(1'b0, 1'b0, 8'h58, 1'b0);
    chk("caps_on", 32'(caps_led), 32'h1);
    ev(1'b1, 1'b0, 8'h1C, 1'b0);
    idle(3, 1'b0);
    chk("a_shift_caps", 32'(ascii_data), 32'h61);
    drain();
    ev(1'b0, 1'b0, 8'h12, 1'b0);
    ev(1'b1, 1'b0, 8'h58, 1'b0);
    ev(1'b0, 1'b0, 8'h58, 1'b0);
    chk("caps_off", 32'(caps_led), 32'h0);

    // Ctrl-C, backspace, keypad Enter, ignored extended key.
    ev(1'b1, 1'b1, 8'h14, 1'b0);
    ev(1'b1, 1'b0, 8'h21, 1'b0);
    idle(3, 1'b0);
    chk("ctrl_c", 32'(ascii_data), 32'h03);
    drain();
    ev(1'b0, 1'b1, 8'h14, 1'b0);
    ev(1'b1, 1'b0, 8'h66, 1'b0);
    idle(3, 1'b0);
    chk("bksp", 32'(ascii_data), 32'h7F);
    drain();
    ev(1'b1, 1'b1, 8'h5A, 1'b0);
    idle(3, 1'b0);
    chk("kp_enter", 32'(ascii_data), 32'h0D);
    drain();
    ev(1'b1, 1'b1, 8'h75, 1'b0);
    idle(4, 1'b0);
    chk("ext_ignored", 32'(fifo_count), 32'h0);

    // Nine presses into a depth-8 buffer with no consumer.
    for (int i = 0; i < 9; i++) ev(1'b1, 1'b0, tbl[i][23:16], 1'b0);
    idle(4, 1'b0);
    chk("ovf_count", 32'(fifo_count), 32'(DEPTH));
    chk("ovf_set", 32'(overflow), 32'h1);
    step(1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order", 32'(ascii_data), 32'(tbl[i][15:8]));
      step(1'b1, 1'b0);
    end
    chk("ovf_drained", 32'(fifo_count), 32'h0);

    // Full buffer with a push and pop on the same edge.
    for (int i = 0; i < 8; i++) ev(1'b1, 1'b0, tbl[10+i][23:16], 1'b0);
    idle(3, 1'b0);
    chk("full_count", 32'(fifo_count), 32'(DEPTH));
    ev(1'b1, 1'b0, 8'h1A, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b0);
    chk("pp_count", 32'(fifo_count), 32'(DEPTH));
    chk("pp_no_ovf", 32'(overflow), 32'h0);
    idle(7, 1'b1);
    chk("pp_tail", 32'(ascii_data), 32'h7A);
    drain();

    // Back-to-back toggles, then the same with a reset mid-pipeline.
    ev(1'b1, 1'b0, 8'h22, 1'b0);
    ev(1'b1, 1'b0, 8'h35, 1'b0);
    ev(1'b1, 1'b0, 8'h1A, 1'b0);
    idle(3, 1'b0);
    chk("b2b_count", 32'(fifo_count), 32'h3);
    chk("b2b_0", 32'(ascii_data), 32'h78);
    step(1'b1, 1'b0);
    chk("b2b_1", 32'(ascii_data), 32'h79);
    step(1'b1, 1'b0);
    chk("b2b_2", 32'(ascii_data), 32'h7A);
    step(1'b1, 1'b0);
    ev(1'b1, 1'b0, 8'h58, 1'b0);
    ev(1'b0, 1'b0, 8'h58, 1'b0);
    ev(1'b1, 1'b0, 8'h1C, 1'b0);
    ev(1'b1, 1'b0, 8'h32, 1'b0);
    ev(1'b1, 1'b0, 8'h21, 1'b0);
    idle(1, 1'b0);
    do_reset(ps2_key[10], 1);
    idle(5, 1'b0);
    chk("rst_flush", 32'(fifo_count), 32'h0);
    chk("rst_caps", 32'(caps_led), 32'(CINIT));

    // Random traffic.
    for (int cyc = 0; cyc < 2500; cyc++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1'($urandom_range(0, 1)), 1 + int'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          r   = int'($urandom_range(0, 99));
          ext = 1'b0;
          if (r < 10) code = mods[$urandom_range(0, 3)];
          else if (r < 18) begin
            ext  = 1'b1;
            code = extc[$urandom_range(0, 4)];
          end else if (r < 22) code = (r % 2 == 1) ? 8'h05 : 8'h11;
          else code = tbl[$urandom_range(0, NTBL-1)][23:16];
          pr = ($urandom_range(0, 2) != 0);
          ps2_key = {~ps2_key[10], pr, ext, code};
        end
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_ascii_kbd.md
PS2_ASCII_KBD -- requirements
Module: ps2_ascii_kbd

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, output character buffer depth; power of two, range 2..32.
REQ-002 Parameter CAPS_INIT, default 1'b0, caps-lock state after reset.
REQ-003 clk_sys  in  1  system clock; all logic on its rising edge; one clock only.
REQ-004 reset_n  in  1  reset; asynchronous assert, active-low.
REQ-005 ps2_key  in  11  event word: [10] toggle (event on every change), [9] 1=press/0=release, [8] extended (E0), [7:0] set-2 scancode.
REQ-006 ascii_data  out  8  head-of-buffer character; [7] always 0.
REQ-007 ascii_valid  out  1  buffer not empty.
REQ-008 ascii_ready  in  1  consumer pop; a pop occurs when ascii_valid & ascii_ready are both high at a clock edge.
REQ-009 fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-010 overflow  out  1  sticky: a character was dropped.
REQ-011 ovf_clr  in  1  single-cycle pulse; clears overflow.
REQ-012 caps_led  out  1  current caps-lock state.

Function
REQ-013 Event detect: an event occurs when ps2_key[10] differs from its registered copy; the copy is reloaded every cycle.
REQ-014 On the first clock after reset release, the toggle copy is loaded from ps2_key[10] and no event is generated.
REQ-015 Modifiers: shift = left (0x12) OR right (0x59); ctrl = 0x14 with or without E0. Each is set on press and cleared on release.
REQ-016 Caps (0x58, non-extended) toggles on press only; release has no effect.
REQ-017 Release events and modifier/caps presses produce no character.
REQ-018 Translation uses a synchronous ROM indexed by {shift, scancode}, US layout. Entry 0x00 = no character.
REQ-019 Fixed ROM entries: 0x5A→0x0D, 0x66→0x7F, 0x76→0x1B, 0x0D→0x09, 0x29→0x20.
REQ-020 Extended events produce characters only for E0-0x5A→0x0D and E0-0x4A→'/'. All other extended scancodes are ignored.
REQ-021 Caps inverts the case of letters (0x41–0x5A ↔ 0x61–0x7A) after the shift lookup.
REQ-022 Ctrl: if the result after caps is in 0x40–0x7F, output = result & 0x1F. Ctrl is applied after caps.
REQ-023 Pipeline: three stages (detect/register, ROM lookup, modify/push). It accepts one event per cycle; no event is lost for back-to-back toggles.
REQ-024 Latency: toggle change sampled at edge N with the buffer empty → ascii_valid high after edge N+3, with ascii_data valid in the same cycle.
REQ-025 Buffer is FIFO-ordered. Read and write pointers wrap modulo FIFO_DEPTH.
REQ-026 Push with buffer full and no pop in the same cycle: character dropped, buffer unchanged, overflow set.
REQ-027 Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
REQ-028 Push and pop in the same cycle when count=1: both succeed, ascii_valid stays high.
REQ-029 Pop when empty has no effect.
REQ-030 ovf_clr coincident with a new drop: overflow stays set (set wins).
REQ-031 Modifier state updates in stage 1, so a modifier event affects the next event immediately following it.

Reset
REQ-032 reset_n low, asynchronously: buffer flushed, pointers 0, fifo_count 0, ascii_valid 0, ascii_data 0x00, overflow 0, shift 0, ctrl 0, caps = CAPS_INIT, pipeline valids 0.
REQ-033 Reset asserted mid-pipeline discards in-flight characters; no partial push after release.

Structure
REQ-034 Shared package ps2_kbd_pkg holds the ps2_key field bit positions, modifier/special scancode constants and ASCII constants (CR, DEL, ESC, TAB).
REQ-035 Sub-module ps2_ascii_rom: synchronous 512×8 lookup, input {shift, scancode}, one-cycle latency. The buffer is inline.

Verification
REQ-036 Reset release with ps2_key[10]=1 → no character; fifo_count=0.
REQ-037 Press 0x1C, CAPS_INIT=0 → 'a' (0x61) valid 3 cycles after the toggle. Then shift press, 0x1C → 0x41. Caps on, shift held, 0x1C → 0x61.
REQ-038 Ctrl press (E0-0x14), then 0x21 → 0x03. 0x66 alone → 0x7F. E0-0x5A → 0x0D. E0-0x75 → nothing.
REQ-039 ascii_ready=0, 9 presses, FIFO_DEPTH=8 → fifo_count=8, overflow=1, first 8 characters in order. ovf_clr → overflow=0.
REQ-040 Full buffer, ascii_ready=1 with a simultaneous push → count stays 8, overflow stays 0, the new character is at the tail.
REQ-041 Three back-to-back toggles on consecutive cycles → three characters in order. reset_n pulsed one cycle after the third → buffer empty, caps=CAPS_INIT.
